// File: rtl/ram_pkg.sv
// Shared definitions for the byte-addressed RAM: controller state encoding.
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/byte_ram.sv
// Byte-addressed RAM with big-endian word access, byte enables, unaligned
// wrap-around addressing, a one-deep read response and self-zeroing after reset.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a read response transfers on a rising edge where rsp_valid && rsp_ready, and
// rsp_valid/rsp_data hold until then.
module byte_ram
  import ram_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter int DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  input  logic [DATA_BYTES-1:0]   req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*DATA_BYTES-1:0] rsp_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = 8 * DATA_BYTES;
  localparam int LB    = $clog2(DATA_BYTES);
  localparam int WORDS = DEPTH / DATA_BYTES;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  state_t          state;
  logic [CW-1:0]   init_cnt;
  logic [AW-1:0]   init_base;
  logic            accept;
  logic            wr_fire;
  logic            rd_fire;

  logic [7:0]      mem      [DEPTH];
  logic [7:0]      mem_next [DEPTH];
  logic [AW-1:0]   lane_addr [DATA_BYTES];
  logic [DATA_BYTES-1:0] lane_we;
  logic [DW-1:0]   rd_word;

  assign req_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign wr_fire   = accept && req_we;
  assign rd_fire   = accept && !req_we;
  assign init_base = AW'(init_cnt) << LB;

  // Lane i carries the i-th byte counted from the MSB; its address wraps mod DEPTH.
  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
    assign lane_addr[i]            = req_addr + AW'(i);
    assign lane_we[i]              = wr_fire && req_be[DATA_BYTES-1-i];
    assign rd_word[DW-1-8*i -: 8]  = mem[lane_addr[i]];
  end

  always_comb begin
    mem_next = mem;
    if (state == INIT) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        mem_next[init_base + AW'(i)] = 8'h00;
      end
    end else begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (lane_we[i]) begin
          mem_next[lane_addr[i]] = req_wdata[DW-1-8*i -: 8];
        end
      end
    end
  end

  // Storage is deliberately not reset; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    mem <= mem_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + CW'(1);
          if (init_cnt == LAST_WORD) begin
            state <= IDLE;
          end
        end
        IDLE:    state <= IDLE;
        default: state <= INIT;
      endcase

      if (rd_fire) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rd_word;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_ram.sv
// Self-checking bench for byte_ram: directed scenarios then a randomized mix,
// checked against a byte-array memory model and a response queue.
module tb_byte_ram;

  localparam int DB    = 2;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 16;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DB-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]    model_mem [DEPTH];
  logic [DW-1:0] exp_q[$];

  byte_ram #(.DATA_BYTES(DB), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_word(input int addr);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < DB; i++) begin
      w = {w[DW-9:0], model_mem[(addr + i) % DEPTH]};
    end
    return w;
  endfunction

  function automatic void model_write(input int addr, input logic [DW-1:0] data,
                                      input logic [DB-1:0] be);
    for (int i = 0; i < DB; i++) begin
      if (be[DB-1-i]) model_mem[(addr + i) % DEPTH] = data[DW-1-8*i -: 8];
    end
  endfunction

  function automatic void model_clear();
    for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
  endfunction

  // Waits out the post-reset clearing sweep, bounded, and checks its length.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_init_cycles"}, 64'(n), 64'(DEPTH / DB));
    chk({tag, "_ready_after_init"}, 64'(req_ready), 64'd1);
    model_clear();
  endtask

  // One clock cycle of stimulus, with model update and output checks.
  task automatic cycle(input logic v, input logic we, input int addr,
                       input logic [DW-1:0] data, input logic [DB-1:0] be,
                       input logic rr);
    logic exp_ready;
    logic acc;
    req_valid = v;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = data;
    req_be    = be;
    rsp_ready = rr;
    #1;
    exp_ready = (exp_q.size() == 0) || rr;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    if (rr && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) begin
      if (we) model_write(addr, data, be);
      else    exp_q.push_back(model_word(addr));
    end
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("rsp_data", 64'(rsp_data), 64'(exp_q[0]));
  endtask

  initial begin
    logic [31:0] r;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    model_clear();

    // reset state
    #23;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    rst_n = 1'b1;
    wait_init("boot");

    // cleared memory reads back zero
    cycle(1'b1, 1'b0, 'h10, 16'h0, 2'b00, 1'b1);
    chk("read_0x10", 64'(rsp_data), 64'h0000);
    cycle(1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b1);

    // aligned write, aligned and unaligned readback
    cycle(1'b1, 1'b1, 'h20, 16'hBEEF, 2'b11, 1'b1);
    cycle(1'b1, 1'b0, 'h20, 16'h0, 2'b00, 1'b1);
    chk("read_0x20", 64'(rsp_data), 64'hBEEF);
    cycle(1'b1, 1'b0, 'h21, 16'h0, 2'b11, 1'b1);
    chk("read_0x21", 64'(rsp_data), 64'hEF00);

    // wrap at top of memory
    cycle(1'b1, 1'b1, 'hFF, 16'h1234, 2'b11, 1'b1);
    cycle(1'b1, 1'b0, 'hFF, 16'h0, 2'b00, 1'b1);
    chk("read_0xFF_wrap", 64'(rsp_data), 64'h1234);
    cycle(1'b1, 1'b0, 'h00, 16'h0, 2'b00, 1'b1);
    chk("read_0x00_wrap", 64'(rsp_data), 64'h3400);

    // partial byte enables, then an all-disabled write that must change nothing
    cycle(1'b1, 1'b1, 'h40, 16'hAAAA, 2'b11, 1'b1);
    cycle(1'b1, 1'b1, 'h40, 16'h5555, 2'b01, 1'b1);
    cycle(1'b1, 1'b1, 'h40, 16'hFFFF, 2'b00, 1'b1);
    chk("be0_no_rsp", 64'(rsp_valid), 64'd0);
    cycle(1'b1, 1'b0, 'h40, 16'h0, 2'b00, 1'b1);
    chk("read_0x40_be", 64'(rsp_data), 64'hAA55);
    cycle(1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b1);

    // response held under back-pressure
    cycle(1'b1, 1'b0, 'h20, 16'h0, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 'h40, 16'h0, 2'b00, 1'b0);
      chk("hold_data", 64'(rsp_data), 64'hBEEF);
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    cycle(1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b1);
    chk("drop_valid", 64'(rsp_valid), 64'd0);

    // back-to-back reads: one response per cycle
    for (int k = 0; k < 8; k++) begin
      r = $urandom;
      cycle(1'b1, 1'b0, int'(r[7:0]), 16'h0, 2'b00, 1'b1);
      chk("b2b_valid", 64'(rsp_valid), 64'd1);
    end
    cycle(1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b1);

    // randomized mix with random back-pressure
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      cycle($urandom_range(0, 3) != 0, r[16], int'(r[7:0]), 16'($urandom),
            DB'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    end
    cycle(1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b1);

    // reset while a response is pending, then the clearing sweep reruns
    cycle(1'b1, 1'b1, 'h80, 16'hC0DE, 2'b11, 1'b1);
    cycle(1'b1, 1'b0, 'h80, 16'h0, 2'b00, 1'b0);
    chk("pre_reset_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 64'(rsp_valid), 64'd0);
    chk("mid_reset_data", 64'(rsp_data), 64'd0);
    chk("mid_reset_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    #15;
    rst_n = 1'b1;
    wait_init("rerun");
    cycle(1'b1, 1'b0, 'h80, 16'h0, 2'b00, 1'b1);
    chk("read_after_rerun", 64'(rsp_data), 64'h0000);
    cycle(1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_ram.md
BYTE_RAM -- requirements
Module: byte_ram

Interface
REQ-001 The block SHALL have parameter DATA_BYTES, default 2, giving bytes per word (1, 2, 4 or 8).
REQ-002 The block SHALL have parameter DEPTH, default 256, giving total bytes; it is a power of two and a multiple of DATA_BYTES.
REQ-003 The block SHALL derive localparam AW = clog2(DEPTH) as the address width and DW = 8*DATA_BYTES as the data width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 means write, 0 means read.
REQ-009 The block SHALL have port req_addr, input, AW bits: byte address of the most significant byte.
REQ-010 The block SHALL have port req_wdata, input, DW bits: write data, big-endian, MSB byte at req_addr.
REQ-011 The block SHALL have port req_be, input, DATA_BYTES bits: byte enables; bit DATA_BYTES-1 selects the byte at req_addr.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: read data is valid.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the read data.
REQ-014 The block SHALL have port rsp_data, output, DW bits: read data, big-endian.

Function
REQ-015 A request SHALL be accepted in a cycle when req_valid and req_ready are both 1 at the rising edge.
REQ-016 Storage SHALL be a byte array of DEPTH entries; byte i of a word (i=0 is MSB) SHALL map to address (req_addr+i) mod DEPTH, so accesses are unaligned-capable and wrap at the top of memory.
REQ-017 An accepted write SHALL update only the enabled bytes at that edge; a write with req_be=0 SHALL change nothing and SHALL complete without a response.
REQ-018 An accepted read SHALL capture data at that edge and present it on rsp_data with rsp_valid=1 from the next cycle (latency 1); req_be SHALL be ignored for reads.
REQ-019 rsp_valid and rsp_data SHALL hold stable until a cycle with rsp_ready=1.
REQ-020 req_ready SHALL equal (state==IDLE) AND (rsp_valid==0 OR rsp_ready==1), which allows back-to-back reads at full rate.
REQ-021 A read accepted the cycle after a write to an overlapping address SHALL return the newly written bytes.
REQ-022 When rsp_ready=1 and no new read is accepted in the same cycle, rsp_valid SHALL drop to 0 on the next edge.
REQ-023 The state machine SHALL have states INIT and IDLE.
REQ-024 In INIT, a counter SHALL zero DATA_BYTES bytes per cycle from address 0 upward; the block SHALL move to IDLE after DEPTH/DATA_BYTES cycles.
REQ-025 req_ready SHALL be 0 throughout INIT.

Reset
REQ-026 While rst_n=0, the block SHALL force state=INIT, the init counter to 0, rsp_valid=0, rsp_data=0, and req_ready=0.
REQ-027 A reset asserted mid-operation SHALL discard any pending response and restart INIT; memory contents SHALL not be guaranteed until INIT completes.
REQ-028 The first cycle in which req_ready can be 1 SHALL be DEPTH/DATA_BYTES cycles after rst_n deasserts.

Structure
REQ-029 The state enum (INIT, IDLE) SHALL reside in shared package ram_pkg.
REQ-030 The block SHALL need no sub-module; byte-lane addressing SHALL be a generate loop over DATA_BYTES.

Verification
REQ-031 Reset release with defaults -> req_ready=0 for 128 cycles, then 1; a read of address 0x10 returns 0x0000.
REQ-032 Write 0xBEEF to 0x20 with be=11, then read 0x20 -> rsp_data=0xBEEF; a read of 0x21 returns 0xEF00.
REQ-033 Write 0x1234 to 0xFF (wrap) -> memory[0xFF]=0x12 and memory[0x00]=0x34; a read of 0xFF returns 0x1234.
REQ-034 Write 0xAAAA to 0x40 with be=11, then 0x5555 with be=01 -> a read returns 0xAA55.
REQ-035 Read 0x20 with rsp_ready held 0 for 3 cycles -> rsp_valid and rsp_data stay stable and req_ready=0; with rsp_ready=1 and back-to-back reads, the bench sees one response per cycle.
REQ-036 rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately, then INIT reruns for 128 cycles.
